// File: rtl/sm83_dma_pkg.sv
// Shared types and constants for the SM83 OAM DMA arbiter.
package sm83_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } dma_state_e;

    localparam logic [15:0] HRAM_LO      = 16'hFF80;
    localparam logic [15:0] HRAM_HI      = 16'hFFFE;
    localparam logic [15:0] DEF_REG_ADDR = 16'hFF46;
    localparam int          DEF_OAM_LEN  = 160;

    localparam int RD_PH_LAST = 1;
    localparam int WR_PH      = 2;

endpackage

// File: rtl/dma_seq_counter.sv
// Machine-cycle phase counter and OAM byte index for the DMA sequencer.
module dma_seq_counter #(
    parameter int M_CLKS  = 4,
    parameter int OAM_LEN = 160,
    parameter int PH_W    = $clog2(M_CLKS),
    parameter int IDX_W   = $clog2(OAM_LEN)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             idx_en_i,
    output logic [PH_W-1:0]  phase_o,
    output logic [IDX_W-1:0] index_o,
    output logic             slot_done_o,
    output logic             last_o
);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(M_CLKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OAM_LEN - 1);

    logic [PH_W-1:0]  phase_q, phase_d;
    logic [IDX_W-1:0] index_q, index_d;

    assign slot_done_o = (phase_q == PH_LAST);
    assign last_o      = (index_q == IDX_LAST);
    assign phase_o     = phase_q;
    assign index_o     = index_q;

    always_comb begin
        phase_d = slot_done_o ? '0 : phase_q + PH_W'(1);
        index_d = index_q;
        if (idx_en_i && slot_done_o) begin
            index_d = last_o ? '0 : index_q + IDX_W'(1);
        end
        if (clr_i) begin
            phase_d = '0;
            index_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= '0;
            index_q <= '0;
        end else begin
            phase_q <= phase_d;
            index_q <= index_d;
        end
    end

endmodule

// File: rtl/oam_dma_arbiter.sv
// OAM DMA sequencer and CPU/DMA bus arbiter with HRAM fencing during copies.
// Optional macro OAM_DMA_SRC_MIRROR_EN folds echo-RAM sources (E0-FF) onto C000-DFFF.
module oam_dma_arbiter
    import sm83_dma_pkg::*;
#(
    parameter int          M_CLKS   = 4,
    parameter int          OAM_LEN  = DEF_OAM_LEN,
    parameter logic [15:0] REG_ADDR = DEF_REG_ADDR
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic [15:0] CPU_A,
    input  logic [7:0]  CPU_DO,
    input  logic        CPU_RD,
    input  logic        CPU_WR,
    output logic [7:0]  CPU_DI,
    output logic [15:0] EXT_A,
    output logic [7:0]  EXT_DO,
    input  logic [7:0]  EXT_DI,
    output logic        EXT_RD,
    output logic        EXT_WR,
    output logic [7:0]  OAM_A,
    output logic [7:0]  OAM_D,
    output logic        OAM_WR,
    output logic        DMA_BUSY
);

    localparam int PH_W  = $clog2(M_CLKS);
    localparam int IDX_W = $clog2(OAM_LEN);

    dma_state_e       state_q;
    logic [7:0]       src_q;
    logic [7:0]       latch_q;
    logic             oam_wr_q;

    logic [PH_W-1:0]  phase;
    logic [IDX_W-1:0] index;
    logic             slot_done;
    logic             last_byte;

    logic             reg_hit, reg_wr, reg_rd, hram_hit, dma_ph;
    logic [7:0]       src_bus;

    assign reg_hit  = (CPU_A == REG_ADDR);
    assign reg_wr   = CPU_WR && reg_hit;
    assign reg_rd   = CPU_RD && reg_hit;
    assign hram_hit = (CPU_A >= HRAM_LO) && (CPU_A <= HRAM_HI);
    assign dma_ph   = (state_q == XFER) && (phase < PH_W'(WR_PH));

`ifdef OAM_DMA_SRC_MIRROR_EN
    assign src_bus = (src_q >= 8'hE0) ? (src_q & 8'hDF) : src_q;
`else
    assign src_bus = src_q;
`endif

    dma_seq_counter #(
        .M_CLKS  (M_CLKS),
        .OAM_LEN (OAM_LEN),
        .PH_W    (PH_W),
        .IDX_W   (IDX_W)
    ) u_seq (
        .clk_i       (CLK),
        .rst_ni      (nRESET),
        .clr_i       (reg_wr),
        .idx_en_i    (state_q == XFER),
        .phase_o     (phase),
        .index_o     (index),
        .slot_done_o (slot_done),
        .last_o      (last_byte)
    );

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= IDLE;
            src_q    <= 8'hFF;
            latch_q  <= 8'hFF;
            oam_wr_q <= 1'b0;
        end else begin
            oam_wr_q <= 1'b0;
            if (reg_wr) begin
                src_q   <= CPU_DO;
                state_q <= START;
            end else begin
                case (state_q)
                    IDLE: begin
                    end
                    START: begin
                        if (slot_done) state_q <= XFER;
                    end
                    XFER: begin
                        if (phase == PH_W'(RD_PH_LAST)) begin
                            latch_q  <= EXT_DI;
                            oam_wr_q <= 1'b1;
                        end
                        if (slot_done && last_byte) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // A restart write in the same clock as a pending OAM strobe kills that strobe.
    assign OAM_WR   = oam_wr_q && !reg_wr;
    assign OAM_A    = 8'(index);
    assign OAM_D    = latch_q;
    assign DMA_BUSY = (state_q != IDLE);

    always_comb begin
        EXT_A  = CPU_A;
        EXT_DO = CPU_DO;
        EXT_RD = CPU_RD;
        EXT_WR = CPU_WR && !reg_hit;
        CPU_DI = EXT_DI;
        if (state_q == XFER) begin
            if (dma_ph) begin
                EXT_A  = {src_bus, 8'(index)};
                EXT_RD = 1'b1;
                EXT_WR = 1'b0;
            end else if (!hram_hit) begin
                EXT_RD = 1'b0;
                EXT_WR = 1'b0;
            end
            if (!hram_hit) CPU_DI = 8'hFF;
        end
        if (reg_rd) CPU_DI = src_q;
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Self-checking bench for oam_dma_arbiter: OAM writes are scoreboarded against a queue.
module tb_oam_dma_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_do;
    logic        cpu_rd, cpu_wr;
    logic [7:0]  cpu_di;
    logic [15:0] ext_a;
    logic [7:0]  ext_do;
    logic [7:0]  ext_di;
    logic        ext_rd, ext_wr;
    logic [7:0]  oam_a, oam_d;
    logic        oam_wr, busy;
    logic [7:0]  di_xor;

    typedef struct packed {
        logic [15:0] ea;
        logic [7:0]  oa;
        logic [7:0]  od;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          pulses = 0;
    logic [15:0] dma_a;
    logic        dma_a_vld = 1'b0;

    always #5 clk = ~clk;

    // Memory model: read data is the low address byte, optionally scrambled.
    assign ext_di = ext_a[7:0] ^ di_xor;

    oam_dma_arbiter dut (
        .CLK      (clk),
        .nRESET   (rst_n),
        .CPU_A    (cpu_a),
        .CPU_DO   (cpu_do),
        .CPU_RD   (cpu_rd),
        .CPU_WR   (cpu_wr),
        .CPU_DI   (cpu_di),
        .EXT_A    (ext_a),
        .EXT_DO   (ext_do),
        .EXT_DI   (ext_di),
        .EXT_RD   (ext_rd),
        .EXT_WR   (ext_wr),
        .OAM_A    (oam_a),
        .OAM_D    (oam_d),
        .OAM_WR   (oam_wr),
        .DMA_BUSY (busy)
    );

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && busy && ext_rd && ext_a[15:8] != 8'hFF) begin
            dma_a     = ext_a;
            dma_a_vld = 1'b1;
        end
        if (rst_n && oam_wr) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL oam_wr_unexpected: got OAM_A=%h OAM_D=%h, expected no pulse", oam_a, oam_d);
            end else begin
                e = exp_q.pop_front();
                if ({dma_vld_or_x(), oam_a, oam_d} !== {e.ea, e.oa, e.od}) begin
                    errors++;
                    $display("FAIL oam_copy: got EXT_A=%h OAM_A=%h OAM_D=%h, expected EXT_A=%h OAM_A=%h OAM_D=%h",
                             dma_vld_or_x(), oam_a, oam_d, e.ea, e.oa, e.od);
                end
            end
            dma_a_vld = 1'b0;
        end
    end

    function automatic logic [15:0] dma_vld_or_x();
        return dma_a_vld ? dma_a : 16'hxxxx;
    endfunction

    function automatic logic [7:0] bus_src(input logic [7:0] s);
`ifdef OAM_DMA_SRC_MIRROR_EN
        return (s >= 8'hE0) ? (s & 8'hDF) : s;
`else
        return s;
`endif
    endfunction

    task automatic push_copy(input logic [7:0] src, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.ea = {bus_src(src), 8'(i)};
            e.oa = 8'(i);
            e.od = 8'(i) ^ di_xor;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle_bus();
        cpu_a  = 16'h0000;
        cpu_do = 8'h00;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    // Called one step after a rising edge; returns one step after the write edge.
    task automatic write_reg(input logic [7:0] v);
        cpu_a  = 16'hFF46;
        cpu_do = v;
        cpu_rd = 1'b0;
        cpu_wr = 1'b1;
        @(posedge clk);
        #1;
        idle_bus();
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_bus();
        di_xor = 8'h00;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (oam_wr !== 1'b0) begin errors++; $display("FAIL rst_oam_wr: got %b expected 0", oam_wr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if ({oam_a, oam_d} !== 16'h00FF) begin errors++; $display("FAIL rst_oam_ad: got %h expected 00ff", {oam_a, oam_d}); end
        rst_n = 1'b1;
        cpu_a = 16'hFF46; cpu_rd = 1'b1;
        #1;
        checks++; if (cpu_di !== 8'hFF) begin errors++; $display("FAIL rst_src_read: got %h expected ff", cpu_di); end
        cpu_rd = 1'b0; cpu_a = 16'h1234; cpu_do = 8'hAB; cpu_wr = 1'b1;
        #1;
        checks++;
        if ({ext_a, ext_do, ext_wr, ext_rd} !== {16'h1234, 8'hAB, 1'b1, 1'b0}) begin
            errors++; $display("FAIL idle_pass_wr: got A=%h DO=%h WR=%b RD=%b expected 1234 ab 1 0", ext_a, ext_do, ext_wr, ext_rd);
        end
        cpu_wr = 1'b0; cpu_a = 16'h4321; cpu_rd = 1'b1; di_xor = 8'h10;
        #1;
        checks++;
        if ({cpu_di, ext_rd, ext_a} !== {8'h31, 1'b1, 16'h4321}) begin
            errors++; $display("FAIL idle_pass_rd: got DI=%h RD=%b A=%h expected 31 1 4321", cpu_di, ext_rd, ext_a);
        end
        di_xor = 8'h00;
        idle_bus();
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_copy();
        int cnt;
        pulses = 0;
        push_copy(8'hC1, 160);
        cpu_a = 16'hFF46; cpu_do = 8'hC1; cpu_wr = 1'b1;
        #1;
        checks++; if (ext_wr !== 1'b0) begin errors++; $display("FAIL reg_wr_not_forwarded: got EXT_WR=%b expected 0", ext_wr); end
        @(posedge clk);
        #1;
        idle_bus();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b expected 1", busy); end
        wait_idle(cnt);
        checks++; if (cnt !== 644) begin errors++; $display("FAIL busy_len: got %0d clocks expected 644", cnt); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL copy_missing: got %0d pending expected 0", exp_q.size()); end
        repeat (8) @(posedge clk);
        #1;
        checks++; if (pulses !== 160) begin errors++; $display("FAIL pulse_count: got %0d expected 160", pulses); end
        cpu_a = 16'hC000; cpu_rd = 1'b1;
        #1;
        checks++;
        if ({cpu_di, ext_a, ext_rd} !== {8'h00, 16'hC000, 1'b1}) begin
            errors++; $display("FAIL pass_restored: got DI=%h A=%h RD=%b expected 00 c000 1", cpu_di, ext_a, ext_rd);
        end
        idle_bus();
        @(posedge clk);
        #1;
    endtask

    task automatic test_fencing();
        int cnt;
        push_copy(8'hC1, 160);
        write_reg(8'hC1);
        repeat (4) @(posedge clk);
        #1;
        cpu_a = 16'hC000; cpu_rd = 1'b1;
        #1;
        checks++;
        if ({cpu_di, ext_rd, ext_a} !== {8'hFF, 1'b1, 16'hC100}) begin
            errors++; $display("FAIL fence_rd_block: got DI=%h RD=%b A=%h expected ff 1 c100", cpu_di, ext_rd, ext_a);
        end
        @(posedge clk); #1;
        cpu_rd = 1'b0; cpu_a = 16'h8000; cpu_do = 8'h55; cpu_wr = 1'b1;
        #1;
        checks++; if (ext_wr !== 1'b0) begin errors++; $display("FAIL fence_wr_block: got EXT_WR=%b expected 0", ext_wr); end
        @(posedge clk); #1;
        cpu_a = 16'hFF90; cpu_do = 8'h77;
        @(posedge clk); #1;
        checks++;
        if ({ext_wr, ext_a, ext_do} !== {1'b1, 16'hFF90, 8'h77}) begin
            errors++; $display("FAIL fence_hram_wr: got WR=%b A=%h DO=%h expected 1 ff90 77", ext_wr, ext_a, ext_do);
        end
        @(posedge clk); #1;
        checks++;
        if ({ext_wr, ext_a} !== {1'b0, 16'hC101}) begin
            errors++; $display("FAIL fence_hram_hold: got WR=%b A=%h expected 0 c101", ext_wr, ext_a);
        end
        @(posedge clk); #1;
        cpu_wr = 1'b0; cpu_rd = 1'b1;
        #1;
        checks++; if (cpu_di !== 8'h01) begin errors++; $display("FAIL fence_hram_rd_dma: got %h expected 01", cpu_di); end
        @(posedge clk); #1;
        cpu_a = 16'hFF46;
        #1;
        checks++; if (cpu_di !== 8'hC1) begin errors++; $display("FAIL fence_reg_rd: got %h expected c1", cpu_di); end
        @(posedge clk); #1;
        cpu_a = 16'hC000;
        #1;
        checks++;
        if ({cpu_di, ext_rd} !== {8'hFF, 1'b0}) begin
            errors++; $display("FAIL fence_rd_ph3: got DI=%h RD=%b expected ff 0", cpu_di, ext_rd);
        end
        idle_bus();
        wait_idle(cnt);
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL fence_copy: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_restart();
        int cnt;
        push_copy(8'hC1, 50);
        write_reg(8'hC1);
        repeat (204) @(posedge clk);
        #1;
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL restart_pre: got %0d pending expected 0", exp_q.size()); end
        push_copy(8'hD0, 160);
        write_reg(8'hD0);
        wait_idle(cnt);
        checks++; if (cnt !== 644) begin errors++; $display("FAIL restart_len: got %0d clocks expected 644", cnt); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL restart_copy: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_abort();
        pulses = 0;
        push_copy(8'hC1, 10);
        write_reg(8'hC1);
        repeat (46) @(posedge clk);
        #1;
        checks++; if (oam_wr !== 1'b1) begin errors++; $display("FAIL abort_pre_pulse: got %b expected 1", oam_wr); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({oam_wr, busy} !== 2'b00) begin
            errors++; $display("FAIL abort_now: got OAM_WR=%b BUSY=%b expected 0 0", oam_wr, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        cpu_a = 16'hFF46; cpu_rd = 1'b1;
        #1;
        checks++; if (cpu_di !== 8'hFF) begin errors++; $display("FAIL abort_src: got %h expected ff", cpu_di); end
        idle_bus();
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (pulses !== 10 || exp_q.size() !== 0) begin
            errors++; $display("FAIL abort_pulses: got %0d pulses %0d pending expected 10 0", pulses, exp_q.size());
        end
    endtask

    task automatic test_mirror();
        int cnt;
        di_xor = 8'h3C;
        push_copy(8'hE3, 160);
        write_reg(8'hE3);
        cpu_a = 16'hFF46; cpu_rd = 1'b1;
        #1;
        checks++; if (cpu_di !== 8'hE3) begin errors++; $display("FAIL mirror_reg_rd: got %h expected e3", cpu_di); end
        idle_bus();
        wait_idle(cnt);
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL mirror_copy: got %0d pending expected 0", exp_q.size()); end
        di_xor = 8'h00;
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_fencing();
        test_restart();
        test_reset_abort();
        test_mirror();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
